pc_redirect_ctrl: RTL
=====================

Name: pc_redirect_ctrl

Overview:
- Control counterpart to the fetch stage. Generates `pc_write`, `pc_write_back_value` and `clear_instruction` for fetch each cycle.
- Arbitrates sequential advance, branch redirects, RET redirects, hazard stalls, two-word instruction immediates and external interrupt entry.
- Sits between fetch and the decode/execute/memory/hazard units.

Parameters:
- `DRAIN_CYCLES`, 3, cycles fetch is held with NOP injection before interrupt save.
- `INT_VECTOR_BASE`, 0, address of interrupt slot 0 in instruction memory.
- `VECTOR_STRIDE`, 1, words per interrupt slot; must be a power of two.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `pc_plus_one`  in  32  fetch's pc+1 (current pc = `pc_plus_one` - 1).
- `is_two_word`  in  1  decoded current fetched instruction carries a 16-bit immediate in the next word.
- `stall`  in  1  hazard unit holds fetch.
- `branch_taken`  in  1  execute-stage taken branch/jump/call.
- `branch_target`  in  32  target for `branch_taken`.
- `ret_valid`  in  1  memory stage popped a return address (RET/RTI).
- `ret_address`  in  32  popped address.
- `int_req`  in  1  level-sensitive interrupt request.
- `int_index`  in  5  interrupt number.
- `pc_write`  out  1  load fetch pc this edge.
- `pc_write_back_value`  out  32  value loaded when `pc_write`=1.
- `clear_instruction`  out  1  fetch substitutes NOP (0x4000).
- `save_valid`  out  1  return-address push request to stack unit.
- `save_ready`  in  1  stack unit accepts push.
- `save_pc`  out  32  return address to push.
- `int_ack`  out  1  one-cycle pulse on vector load.

Behaviour:
- States: RUN, INT_DRAIN, INT_SAVE, INT_VECTOR. Registers: `state`, `imm_pending`, `drain_cnt`, `saved_pc`, `saved_index`.
- Outputs are combinational from state, registers and inputs. Fetch registers the pc on the following edge.
- Reset (async): `state`=RUN, `imm_pending`=0, `drain_cnt`=0, `saved_pc`=0, `saved_index`=0. Consequently `pc_write`=0, `clear_instruction`=0, `save_valid`=0, `int_ack`=0, `pc_write_back_value`=0, `save_pc`=0 while reset is high. Reset mid-interrupt abandons the sequence with no push.
- RUN priority, highest first:
  1. `ret_valid`: `pc_write`=1, value=`ret_address`, `clear_instruction`=1, `imm_pending`<=0.
  2. `branch_taken`: `pc_write`=1, value=`branch_target`, `clear_instruction`=1, `imm_pending`<=0.
  3. `stall`: `pc_write`=0, `clear_instruction`=0, all registers hold.
  4. Interrupt take: `int_req`=1 and `imm_pending`=0.
     - `pc_write`=0, `clear_instruction`=1.
     - `saved_pc`<=`pc_plus_one`-1 (the cleared instruction re-executes after RTI).
     - `saved_index`<=`int_index`, `drain_cnt`<=`DRAIN_CYCLES`-1, state<=INT_DRAIN.
  5. Normal: `pc_write`=1, value=`pc_plus_one`.
     - `clear_instruction`=`imm_pending`; an immediate word must never be decoded.
     - `imm_pending`<=`is_two_word` & ~`imm_pending`.
- Interrupt is never taken while `imm_pending`=1; it is deferred one cycle. Redirects override a same-cycle interrupt; `int_req` is re-sampled next cycle.
- INT_DRAIN:
  - `clear_instruction`=1, `pc_write`=0; `stall` is ignored.
  - A `ret_valid` or `branch_taken` from an in-flight instruction sets `saved_pc`<=the respective target (ret has priority) and reloads `drain_cnt`<=`DRAIN_CYCLES`-1.
  - Otherwise decrement; at 0, state<=INT_SAVE.
- INT_SAVE:
  - `clear_instruction`=1, `save_valid`=1, `save_pc`=`saved_pc`, `pc_write`=0.
  - `save_valid`/`save_pc` stay stable until the `save_ready` handshake; on `save_valid`&`save_ready`, state<=INT_VECTOR.
- INT_VECTOR:
  - `pc_write`=1, value=`INT_VECTOR_BASE`+`saved_index`*`VECTOR_STRIDE` (32-bit, zero-extended index, wraps mod 2^32).
  - `clear_instruction`=1, `int_ack`=1; state<=RUN.
- `int_req` still high on return to RUN re-enters the sequence; the source must drop on `int_ack`.
- Arithmetic is 32-bit unsigned with wrap: `pc_plus_one`=0 gives `saved_pc`=0xFFFFFFFF.

Test Plan:
- Reset high with all inputs active → all outputs 0. Release with `pc_plus_one`=0x21 → `pc_write`=1, value=0x21, `clear_instruction`=0.
- `is_two_word`=1 at `pc_plus_one`=0x25 → next cycle `clear_instruction`=1, `pc_write`=1. The cycle after, `clear_instruction`=0 and `is_two_word` is honoured again.
- `branch_taken`=1, target=0x100, with `stall`=1 and `int_req`=1 in the same cycle → `pc_write`=1, value=0x100, `clear_instruction`=1, state stays RUN.
- `int_req`=1, `int_index`=3, `pc_plus_one`=0x41, `DRAIN_CYCLES`=3, `save_ready`=0 for 2 cycles:
  - 3 NOP cycles with `pc_write`=0.
  - `save_valid` held with `save_pc`=0x40 until `save_ready`.
  - Then `pc_write`=1, value=0x3, `int_ack`=1.
- During INT_DRAIN cycle 2, `branch_taken` with target 0x80 → `save_pc`=0x80 and the drain restarts (3 more cleared cycles).
- `is_two_word` cycle followed by `int_req`=1 → interrupt entry delayed one cycle; `saved_pc` is the address after the immediate word. Reset asserted in INT_SAVE → `save_valid` drops immediately, state RUN.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-side PC control: sequential advance, branch/RET redirects, stalls,
// two-word immediate skipping and interrupt entry (drain, push, vector).
module pc_redirect_ctrl #(
  parameter int unsigned DRAIN_CYCLES    = 3,
  parameter int unsigned INT_VECTOR_BASE = 0,
  parameter int unsigned VECTOR_STRIDE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_plus_one,
  input  logic        is_two_word,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ret_valid,
  input  logic [31:0] ret_address,
  input  logic        int_req,
  input  logic [4:0]  int_index,
  output logic        pc_write,
  output logic [31:0] pc_write_back_value,
  output logic        clear_instruction,
  output logic        save_valid,
  input  logic        save_ready,
  output logic [31:0] save_pc,
  output logic        int_ack
);

  localparam int unsigned CNT_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned STRIDE_SH = (VECTOR_STRIDE > 1) ? $clog2(VECTOR_STRIDE) : 0;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [31:0]      VEC_BASE   = 32'(INT_VECTOR_BASE);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    INT_DRAIN  = 2'd1,
    INT_SAVE   = 2'd2,
    INT_VECTOR = 2'd3
  } state_t;

  state_t           state;
  logic             imm_pending;
  logic [CNT_W-1:0] drain_cnt;
  logic [31:0]      saved_pc;
  logic [4:0]       saved_index;
  logic [31:0]      vector_addr;

  assign vector_addr = VEC_BASE + (32'(saved_index) << STRIDE_SH);

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      imm_pending <= 1'b0;
      drain_cnt   <= '0;
      saved_pc    <= '0;
      saved_index <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ret_valid || branch_taken) begin
            imm_pending <= 1'b0;
          end else if (!stall) begin
            if (int_req && !imm_pending) begin
              // The instruction being cleared now re-executes after RTI.
              saved_pc    <= pc_plus_one - 32'd1;
              saved_index <= int_index;
              drain_cnt   <= DRAIN_LOAD;
              state       <= INT_DRAIN;
            end else begin
              imm_pending <= is_two_word & ~imm_pending;
            end
          end
        end
        INT_DRAIN: begin
          if (ret_valid) begin
            saved_pc  <= ret_address;
            drain_cnt <= DRAIN_LOAD;
          end else if (branch_taken) begin
            saved_pc  <= branch_target;
            drain_cnt <= DRAIN_LOAD;
          end else if (drain_cnt == '0) begin
            state <= INT_SAVE;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        INT_SAVE: begin
          if (save_ready) state <= INT_VECTOR;
        end
        INT_VECTOR: state <= RUN;
        default:    state <= RUN;
      endcase
    end
  end

  // Fetch control, forced quiet while reset is held
  always_comb begin
    pc_write            = 1'b0;
    pc_write_back_value = 32'd0;
    clear_instruction   = 1'b0;
    save_valid          = 1'b0;
    save_pc             = 32'd0;
    int_ack             = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (ret_valid) begin
            pc_write            = 1'b1;
            pc_write_back_value = ret_address;
            clear_instruction   = 1'b1;
          end else if (branch_taken) begin
            pc_write            = 1'b1;
            pc_write_back_value = branch_target;
            clear_instruction   = 1'b1;
          end else if (stall) begin
            pc_write          = 1'b0;
            clear_instruction = 1'b0;
          end else if (int_req && !imm_pending) begin
            clear_instruction = 1'b1;
          end else begin
            pc_write            = 1'b1;
            pc_write_back_value = pc_plus_one;
            clear_instruction   = imm_pending;
          end
        end
        INT_DRAIN: clear_instruction = 1'b1;
        INT_SAVE: begin
          clear_instruction = 1'b1;
          save_valid        = 1'b1;
          save_pc           = saved_pc;
        end
        INT_VECTOR: begin
          pc_write            = 1'b1;
          pc_write_back_value = vector_addr;
          clear_instruction   = 1'b1;
          int_ack             = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
